// File: rtl/execute_mem_pkg.sv
`default_nettype none
// ============================================================================
// execute_mem_pkg : shared widths and slot-state encoding for the mem writeback
// Revision: 1.0
// ============================================================================
package execute_mem_pkg;

  localparam int ROB_IDX_W = 4;
  localparam int DELAY_W   = 4;
  localparam int FID_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/execute_mem_wbslot.sv
`default_nettype none
// ============================================================================
// execute_mem_wbslot : one ROB slot - commit-delay FSM, counter and data store
// Revision: 1.0
// ============================================================================
module execute_mem_wbslot
  import execute_mem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_capture,
  input  logic               i_retire,
  input  logic               i_flush,
  input  logic [FID_W-1:0]   i_fid,
  input  logic [31:0]        i_result,
  input  logic               i_lsmiss,
  input  logic [DELAY_W-1:0] i_cmtdelay,
  output slot_state_t        o_state,
  output logic [FID_W-1:0]   o_fid,
  output logic [31:0]        o_result,
  output logic               o_lsmiss
);

  slot_state_t        r_state, w_state_nxt;
  logic [DELAY_W-1:0] r_cnt, w_cnt_nxt;
  logic [FID_W-1:0]   r_fid;
  logic [31:0]        r_result;
  logic               r_lsmiss;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Priority: flush, then capture (beats a same-cycle retire), then aging.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
    end else if (i_capture) begin
      if (i_cmtdelay == '0) begin
        w_state_nxt = ST_DONE;
      end else begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = i_cmtdelay;
      end
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_cnt == DELAY_W'(1)) w_state_nxt = ST_DONE;
          else                      w_cnt_nxt   = r_cnt - DELAY_W'(1);
        end
        ST_DONE: begin
          if (i_retire) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Payload is not reset; the top gates it with the slot state.
  always_ff @(posedge clk) begin
    if (i_capture && !i_flush) begin
      r_fid    <= i_fid;
      r_result <= i_result;
      r_lsmiss <= i_lsmiss;
    end
  end

  assign o_state  = r_state;
  assign o_fid    = r_fid;
  assign o_result = r_result;
  assign o_lsmiss = r_lsmiss;

endmodule
`default_nettype wire

// File: rtl/execute_mem_wbrecv.sv
`default_nettype none
// ============================================================================
// execute_mem_wbrecv : memory-pipe writeback receiver and ROB head status mux
// Revision: 1.0
// ============================================================================
module execute_mem_wbrecv #(
  parameter int ROB_ENTRIES = 16,
  parameter int DELAY_W     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_valid,
  input  logic [$clog2(ROB_ENTRIES)-1:0] i_dst_rob,
  input  logic [7:0]                     i_fid,
  input  logic [31:0]                    i_result,
  input  logic [DELAY_W-1:0]             i_cmtdelay,
  input  logic                           i_lsmiss,
  input  logic                           i_flush,
  input  logic [$clog2(ROB_ENTRIES)-1:0] i_head_rob,
  input  logic                           i_commit,
  output logic                           o_head_done,
  output logic [31:0]                    o_head_result,
  output logic [7:0]                     o_head_fid,
  output logic                           o_head_lsmiss,
  output logic [4:0]                     o_pending,
  output logic                           o_err
);

  localparam int c_IDX_W = $clog2(ROB_ENTRIES);

  execute_mem_pkg::slot_state_t w_state [ROB_ENTRIES];
  logic [7:0]  w_fid    [ROB_ENTRIES];
  logic [31:0] w_result [ROB_ENTRIES];
  logic        w_lsmiss [ROB_ENTRIES];
  logic [ROB_ENTRIES-1:0] w_capture, w_retire;

  logic       w_retire_eff, w_same_slot, w_inc, w_dec, w_err_set;
  logic [4:0] r_pending;
  logic       r_err;

  assign o_head_done  = (w_state[i_head_rob] == execute_mem_pkg::ST_DONE);
  assign w_retire_eff = i_commit && o_head_done;
  assign w_same_slot  = i_valid && w_retire_eff && (i_dst_rob == i_head_rob);

  generate
    for (genvar i = 0; i < ROB_ENTRIES; i++) begin : g_slot
      assign w_capture[i] = i_valid && (i_dst_rob == c_IDX_W'(i));
      assign w_retire[i]  = w_retire_eff && (i_head_rob == c_IDX_W'(i));

      execute_mem_wbslot u_slot (
        .clk        (clk),
        .reset      (reset),
        .i_capture  (w_capture[i]),
        .i_retire   (w_retire[i]),
        .i_flush    (i_flush),
        .i_fid      (i_fid),
        .i_result   (i_result),
        .i_lsmiss   (i_lsmiss),
        .i_cmtdelay (i_cmtdelay),
        .o_state    (w_state[i]),
        .o_fid      (w_fid[i]),
        .o_result   (w_result[i]),
        .o_lsmiss   (w_lsmiss[i])
      );
    end
  endgenerate

  assign o_head_result = o_head_done ? w_result[i_head_rob] : 32'd0;
  assign o_head_fid    = o_head_done ? w_fid[i_head_rob]    : 8'd0;
  assign o_head_lsmiss = o_head_done && w_lsmiss[i_head_rob];

  // A capture that lands on the slot being retired reuses it: net pending 0.
  assign w_inc = i_valid && (w_state[i_dst_rob] == execute_mem_pkg::ST_IDLE);
  assign w_dec = w_retire_eff && !w_same_slot;
  assign w_err_set = !i_flush &&
                     ((i_commit && !o_head_done) ||
                      (i_valid && !w_inc && !w_same_slot));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_err_set) r_err <= 1'b1;
      if (i_flush)
        r_pending <= '0;
      else if (w_inc && !w_dec && r_pending != 5'(ROB_ENTRIES))
        r_pending <= r_pending + 5'd1;
      else if (w_dec && !w_inc && r_pending != 5'd0)
        r_pending <= r_pending - 5'd1;
    end
  end

  assign o_pending = r_pending;
  assign o_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_execute_mem_wbrecv.sv
`default_nettype none
// ============================================================================
// tb_execute_mem_wbrecv : directed self-checking bench for execute_mem_wbrecv
// Revision: 1.0
// ============================================================================
module tb_execute_mem_wbrecv;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [3:0]  i_dst_rob;
  logic [7:0]  i_fid;
  logic [31:0] i_result;
  logic [3:0]  i_cmtdelay;
  logic        i_lsmiss;
  logic        i_flush;
  logic [3:0]  i_head_rob;
  logic        i_commit;
  logic        o_head_done;
  logic [31:0] o_head_result;
  logic [7:0]  o_head_fid;
  logic        o_head_lsmiss;
  logic [4:0]  o_pending;
  logic        o_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  execute_mem_wbrecv #(.ROB_ENTRIES(16), .DELAY_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (i_valid),
    .i_dst_rob     (i_dst_rob),
    .i_fid         (i_fid),
    .i_result      (i_result),
    .i_cmtdelay    (i_cmtdelay),
    .i_lsmiss      (i_lsmiss),
    .i_flush       (i_flush),
    .i_head_rob    (i_head_rob),
    .i_commit      (i_commit),
    .o_head_done   (o_head_done),
    .o_head_result (o_head_result),
    .o_head_fid    (o_head_fid),
    .o_head_lsmiss (o_head_lsmiss),
    .o_pending     (o_pending),
    .o_err         (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [3:0] slot, input logic [7:0] fid,
                    input logic [31:0] res, input logic [3:0] dly, input logic miss);
    i_valid = 1'b1; i_dst_rob = slot; i_fid = fid;
    i_result = res; i_cmtdelay = dly; i_lsmiss = miss;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic commit();
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
  endtask

  initial begin
    int budget;
    reset = 1'b1; i_valid = 1'b0; i_dst_rob = '0; i_fid = '0; i_result = '0;
    i_cmtdelay = '0; i_lsmiss = 1'b0; i_flush = 1'b0; i_head_rob = '0; i_commit = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_done",    32'(o_head_done),   32'd0);
    chk("rst_result",  o_head_result,      32'd0);
    chk("rst_fid",     32'(o_head_fid),    32'd0);
    chk("rst_lsmiss",  32'(o_head_lsmiss), 32'd0);
    chk("rst_pending", 32'(o_pending),     32'd0);
    chk("rst_err",     32'(o_err),         32'd0);

    // delay-0 writeback is done the next cycle
    i_head_rob = 4'd3;
    wb(4'd3, 8'h5A, 32'hDEADBEEF, 4'd0, 1'b0);
    chk("d0_done",    32'(o_head_done), 32'd1);
    chk("d0_result",  o_head_result,    32'hDEADBEEF);
    chk("d0_fid",     32'(o_head_fid),  32'h5A);
    chk("d0_pending", 32'(o_pending),   32'd1);
    commit();
    chk("d0_retire_pend", 32'(o_pending), 32'd0);

    // delay-5 with miss
    i_head_rob = 4'd7;
    wb(4'd7, 8'h11, 32'h12345678, 4'd5, 1'b1);
    chk("d5_wait0", 32'(o_head_done), 32'd0);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk($sformatf("d5_wait%0d", k), 32'(o_head_done), 32'd0);
    end
    tick();
    chk("d5_done",   32'(o_head_done),   32'd1);
    chk("d5_lsmiss", 32'(o_head_lsmiss), 32'd1);
    chk("d5_result", o_head_result,      32'h12345678);
    commit();
    chk("d5_retire_done", 32'(o_head_done), 32'd0);
    chk("d5_retire_pend", 32'(o_pending),   32'd0);

    // fill every slot, then retire in order
    for (int s = 0; s < 16; s++)
      wb(4'(s), 8'(s + 8'h80), 32'h100 + 32'(s), 4'(s % 4), 1'b0);
    chk("fill_pending", 32'(o_pending), 32'd16);
    for (int s = 0; s < 16; s++) begin
      i_head_rob = 4'(s);
      #1;
      budget = 20;
      while (!o_head_done && budget > 0) begin
        tick();
        budget--;
      end
      chk($sformatf("fill_done%0d", s), 32'(o_head_done), 32'd1);
      chk($sformatf("fill_res%0d", s),  o_head_result,    32'h100 + 32'(s));
      commit();
    end
    chk("drain_pending", 32'(o_pending), 32'd0);
    chk("drain_err",     32'(o_err),     32'd0);

    // commit while head in WAIT
    wb(4'd2, 8'h22, 32'h00000222, 4'd5, 1'b0);
    i_head_rob = 4'd2;
    commit();
    chk("bad_commit_err",  32'(o_err),       32'd1);
    chk("bad_commit_pend", 32'(o_pending),   32'd1);
    chk("bad_commit_done", 32'(o_head_done), 32'd0);

    // overwrite a DONE slot
    wb(4'd4, 8'h44, 32'hAAAA0004, 4'd0, 1'b0);
    wb(4'd4, 8'h45, 32'hBBBB0004, 4'd2, 1'b0);
    i_head_rob = 4'd4;
    #1;
    chk("ovw_pend",  32'(o_pending),   32'd2);
    chk("ovw_wait0", 32'(o_head_done), 32'd0);
    tick();
    chk("ovw_wait1", 32'(o_head_done), 32'd0);
    tick();
    chk("ovw_done",   32'(o_head_done), 32'd1);
    chk("ovw_result", o_head_result,    32'hBBBB0004);
    chk("ovw_fid",    32'(o_head_fid),  32'h45);
    chk("ovw_err",    32'(o_err),       32'd1);

    // flush with DONE (2,4), WAIT (5) and a same-cycle capture into 9
    wb(4'd5, 8'h55, 32'h00000555, 4'd9, 1'b0);
    i_flush = 1'b1;
    wb(4'd9, 8'h99, 32'h00000999, 4'd0, 1'b0);
    i_flush = 1'b0;
    chk("flush_pend", 32'(o_pending), 32'd0);
    i_head_rob = 4'd2; #1; chk("flush_done2", 32'(o_head_done), 32'd0);
    i_head_rob = 4'd4; #1; chk("flush_done4", 32'(o_head_done), 32'd0);
    i_head_rob = 4'd9; #1; chk("flush_done9", 32'(o_head_done), 32'd0);
    i_head_rob = 4'd5;
    for (int k = 0; k < 10; k++) tick();
    chk("flush_done5", 32'(o_head_done), 32'd0);
    chk("flush_err",   32'(o_err),       32'd1);
    i_head_rob = 4'd9;
    commit();
    chk("flush_pend9", 32'(o_pending), 32'd0);

    // retire and recapture the same slot in one cycle
    i_head_rob = 4'd1;
    wb(4'd1, 8'h61, 32'h11110001, 4'd0, 1'b0);
    chk("reuse_pre_done", 32'(o_head_done), 32'd1);
    chk("reuse_pre_pend", 32'(o_pending),   32'd1);
    i_commit = 1'b1;
    wb(4'd1, 8'h62, 32'h22220001, 4'd2, 1'b0);
    i_commit = 1'b0;
    chk("reuse_pend",  32'(o_pending),   32'd1);
    chk("reuse_wait0", 32'(o_head_done), 32'd0);
    tick();
    chk("reuse_wait1", 32'(o_head_done), 32'd0);
    tick();
    chk("reuse_done",   32'(o_head_done), 32'd1);
    chk("reuse_result", o_head_result,    32'h22220001);
    chk("reuse_fid",    32'(o_head_fid),  32'h62);

    // reset mid-WAIT clears state and the sticky error
    wb(4'd6, 8'h66, 32'h00000666, 4'd7, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_head_rob = 4'd6;
    for (int k = 0; k < 8; k++) tick();
    chk("mid_rst_done", 32'(o_head_done), 32'd0);
    chk("mid_rst_pend", 32'(o_pending),   32'd0);
    chk("mid_rst_err",  32'(o_err),       32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_mem_wbrecv.md
# execute_mem_wbrecv

Receiving end of the memory-pipe writeback path. Captures one registered writeback per cycle (valid, destination ROB index, fetch ID, result, commit delay, load/store miss), holds it in a 16-slot per-ROB-entry table, counts out the commit delay, and presents done/result/miss status for the ROB commit head. Sits between the memory execute output flops and the ROB commit logic.

## Interface
- `ROB_ENTRIES`, 16, number of ROB slots (index width 4)
- `DELAY_W`, 4, commit-delay counter width
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; one clock with reset high clears all state
- `i_valid`  in  1  writeback valid this cycle
- `i_dst_rob`  in  4  destination ROB slot
- `i_fid`  in  8  fetch ID of the instruction
- `i_result`  in  32  load result / store data
- `i_cmtdelay`  in  4  cycles before the slot may commit
- `i_lsmiss`  in  1  access missed; commit logic replays
- `i_flush`  in  1  pipeline flush; drop all slots
- `i_head_rob`  in  4  current ROB commit head index
- `i_commit`  in  1  commit logic retires the head slot this cycle
- `o_head_done`  out  1  head slot is DONE
- `o_head_result`  out  32  head result, forced 0 unless `o_head_done`
- `o_head_fid`  out  8  head fetch ID, forced 0 unless `o_head_done`
- `o_head_lsmiss`  out  1  head miss flag, forced 0 unless `o_head_done`
- `o_pending`  out  5  number of non-IDLE slots (0..16)
- `o_err`  out  1  sticky protocol-error flag

## Operation
- Per-slot state machine, states IDLE, WAIT, DONE; per-slot count register `cnt[3:0]`, plus `fid`, `result`, `lsmiss` storage.
- Capture (i_valid, slot = i_dst_rob): store fid/result/lsmiss; if `i_cmtdelay==0`, state to DONE; else state to WAIT, `cnt <= i_cmtdelay`.
- WAIT: each edge, if `cnt==1`, state to DONE; else `cnt <= cnt-1`.
- DONE: hold until retired. Retire (i_commit with `o_head_done`): slot `i_head_rob` goes to IDLE.
- `i_commit` while head not DONE: ignored, sets `o_err`.
- Capture into a non-IDLE slot: overwrite (new data, restart delay), set `o_err`.
- Capture and retire of the same slot in one cycle: capture wins, slot holds new data. `o_pending` is unchanged.
- `i_flush`: all slots go to IDLE on the next edge. Flush overrides same-cycle capture and retire. `o_err` is not cleared.
- `o_pending` is a registered counter: +1 on capture into an IDLE slot, −1 on an effective retire, both in one cycle gives net 0, flush sets it to 0. It never exceeds 16.
- `o_err` is cleared only by reset.
- Storage arrays are not reset. Outputs are gated by state, so no X reaches the outputs.

## Timing
- Reset values: every slot IDLE, `o_head_done=0`, `o_head_result=0`, `o_head_fid=0`, `o_head_lsmiss=0`, `o_pending=0`, `o_err=0`.
- Head outputs are combinational from registered slot state indexed by `i_head_rob`; there is no added latency.
- Capture at edge E0 with delay d: `o_head_done` is visible (head = that slot) in the cycle after edge E0+d. Total latency from i_valid to done is d+1 cycles.
- A retire at edge E makes the slot IDLE after E. A new capture into it is legal from edge E+1 onward.
- Reset asserted mid-WAIT or mid-DONE: all slots are IDLE after that edge. In-flight delay is discarded.

## Structure
- Shared package `execute_mem_pkg`: `ROB_IDX_W=4`, `DELAY_W=4`, `FID_W=8`, slot-state enum `{ST_IDLE, ST_WAIT, ST_DONE}`.
- One sub-module `execute_mem_wbslot`: a single slot's FSM, counter, and storage, with capture/retire/flush inputs and state/data outputs. The top instantiates 16 slots, decodes capture/retire, muxes the head, and holds the pending counter and error flag.

## Test plan
- Reset then idle: all outputs are 0. Writeback slot 3, delay 0, result 0xDEADBEEF, fid 0x5A, head=3: done=1 the next cycle with result 0xDEADBEEF, fid 0x5A, pending=1.
- Writeback slot 7, delay 5, lsmiss=1, head=7: done stays 0 for 5 cycles and goes to 1 in the 6th with lsmiss=1. Commit: done=0 and pending=0 the next cycle.
- 16 back-to-back writebacks to slots 0..15 with mixed delays: pending reaches 16. Retire in order 0..15, each as it becomes done: pending returns to 0 and `o_err` stays 0.
- Commit with head slot 2 in WAIT: nothing retires and `o_err`=1. Writeback to already-DONE slot 4: new data is visible after its delay and `o_err` stays 1.
- Flush with slots in WAIT and DONE plus a same-cycle writeback to slot 9: the next cycle has all done=0, pending=0, and slot 9 IDLE.
- Slot 1 DONE, head=1: commit and a new writeback to slot 1 with delay 2 in the same cycle. Pending is unchanged, done=0 for 2 cycles, then 1 with the new result.
